// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that registers one finished result per cycle onto the common data bus.
// Define CDB_ARB_BR_PRIO_EN to give the branch station (index N_REQ-1) fixed top priority.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 5,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*TAG_W-1:0]     req_tag_i,
  input  logic [N_REQ*DATA_W-1:0]    req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic                       flush_i,
  input  logic                       cdb_stall_i,
  output logic                       cdb_valid_o,
  output logic [TAG_W-1:0]           cdb_tag_o,
  output logic [DATA_W-1:0]          cdb_data_o,
  output logic [$clog2(N_REQ)-1:0]   cdb_src_o
);

  localparam int unsigned SrcW = $clog2(N_REQ);

  logic [SrcW-1:0]   ptr_q, ptr_d;
  logic [SrcW-1:0]   win;
  logic              found;
  logic              br_win;
  logic              grant_en;
  logic              xfer;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SrcW-1:0]   cdb_src_q, cdb_src_d;

  // Rotating scan starting at ptr_q; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    br_win = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = SrcW'(idx);
      end
    end
`ifdef CDB_ARB_BR_PRIO_EN
    if (req_valid_i[N_REQ-1]) begin
      found  = 1'b1;
      win    = SrcW'(N_REQ - 1);
      br_win = 1'b1;
    end
`endif
  end

  // Gating with reset keeps grants silent while the block is held in reset.
  assign grant_en    = reset_ni && !flush_i && !cdb_stall_i;
  assign xfer        = grant_en && found;
  assign req_ready_o = xfer ? (N_REQ'(1) << win) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (xfer) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = req_tag_i[int'(win)*TAG_W +: TAG_W];
      cdb_data_d  = req_data_i[int'(win)*DATA_W +: DATA_W];
      cdb_src_d   = win;
      if (!br_win) begin
        ptr_d = (win == SrcW'(N_REQ - 1)) ? '0 : win + SrcW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed grants queue expected broadcasts, a monitor checks them.
module tb_cdb_arbiter;

  localparam int unsigned N_REQ  = 5;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [2:0]        src;
    int                cyc;
  } exp_t;

  logic                    clk_i = 1'b0;
  logic                    reset_ni;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*TAG_W-1:0]  req_tag_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    flush_i;
  logic                    cdb_stall_i;
  logic                    cdb_valid_o;
  logic [TAG_W-1:0]        cdb_tag_o;
  logic [DATA_W-1:0]       cdb_data_o;
  logic [2:0]              cdb_src_o;

  logic [TAG_W-1:0]  tag_tb  [N_REQ];
  logic [DATA_W-1:0] data_tb [N_REQ];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .req_valid_i (req_valid_i),
    .req_tag_i   (req_tag_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .cdb_stall_i (cdb_stall_i),
    .cdb_valid_o (cdb_valid_o),
    .cdb_tag_o   (cdb_tag_o),
    .cdb_data_o  (cdb_data_o),
    .cdb_src_o   (cdb_src_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_tag_i[i*TAG_W +: TAG_W]    = tag_tb[i];
      req_data_i[i*DATA_W +: DATA_W] = data_tb[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One arbitration cycle: drive after the edge, check the grant, queue any broadcast.
  task automatic step(input logic [4:0] v, input logic fl, input logic st, input logic [4:0] exp);
    exp_t e;
    @(posedge clk_i);
    #1;
    req_valid_i = v;
    flush_i     = fl;
    cdb_stall_i = st;
    #3;
    chk("req_ready", 64'(req_ready_o), 64'(exp));
    for (int i = 0; i < N_REQ; i++) begin
      if (exp[i]) begin
        e.tag  = tag_tb[i];
        e.data = data_tb[i];
        e.src  = 3'(i);
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_ni === 1'b1 && cdb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got src %0d tag %0d expected no broadcast", cdb_src_o,
                 cdb_tag_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_tag", 64'(cdb_tag_o), 64'(e.tag));
        chk("cdb_data", 64'(cdb_data_o), 64'(e.data));
        chk("cdb_src", 64'(cdb_src_o), 64'(e.src));
        chk("cdb_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      tag_tb[i]  = TAG_W'(i + 1);
      data_tb[i] = 32'hC0DE_0000 | DATA_W'(i);
    end
    reset_ni    = 1'b0;
    req_valid_i = '1;
    flush_i     = 1'b0;
    cdb_stall_i = 1'b0;
    #2;
    chk("ready_in_reset", 64'(req_ready_o), 64'd0);
    chk("rst_valid", 64'(cdb_valid_o), 64'd0);
    chk("rst_tag", 64'(cdb_tag_o), 64'd0);
    chk("rst_data", 64'(cdb_data_o), 64'd0);
    chk("rst_src", 64'(cdb_src_o), 64'd0);
    req_valid_i = '0;
    #10;
    reset_ni = 1'b1;

    repeat (5) step(5'b00000, 1'b0, 1'b0, 5'b00000);
    // All requesting: round robin from 0.
    step(5'b11111, 1'b0, 1'b0, 5'b00001);
    step(5'b11111, 1'b0, 1'b0, 5'b00010);
    step(5'b11111, 1'b0, 1'b0, 5'b00100);
    step(5'b11111, 1'b0, 1'b0, 5'b01000);
    step(5'b11111, 1'b0, 1'b0, 5'b10000);
    step(5'b11111, 1'b0, 1'b0, 5'b00001);
    // Single request on 2 with ptr at 1.
    tag_tb[2]  = 3'd5;
    data_tb[2] = 32'hDEAD_BEEF;
    step(5'b00100, 1'b0, 1'b0, 5'b00100);
    step(5'b11111, 1'b0, 1'b0, 5'b01000);
    // Wrap 4 -> 0 -> 1.
    step(5'b10001, 1'b0, 1'b0, 5'b10000);
    step(5'b10001, 1'b0, 1'b0, 5'b00001);
    step(5'b10011, 1'b0, 1'b0, 5'b00010);
    // Flush, stall and both block grants; ptr stays at 2 so 0 wins afterwards.
    step(5'b00011, 1'b1, 1'b0, 5'b00000);
    step(5'b00011, 1'b0, 1'b1, 5'b00000);
    step(5'b00011, 1'b1, 1'b1, 5'b00000);
    step(5'b00011, 1'b0, 1'b0, 5'b00001);
    // Stall does not cancel the broadcast registered by the previous grant.
    step(5'b00000, 1'b0, 1'b1, 5'b00000);
`ifdef CDB_ARB_BR_PRIO_EN
    step(5'b10110, 1'b0, 1'b0, 5'b10000);
    step(5'b00110, 1'b0, 1'b0, 5'b00010);
`else
    step(5'b10110, 1'b0, 1'b0, 5'b00010);
    step(5'b10100, 1'b0, 1'b0, 5'b00100);
`endif
    step(5'b00001, 1'b0, 1'b0, 5'b00001);
    // Async reset while that broadcast is on the bus.
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    chk("pre_reset_valid", 64'(cdb_valid_o), 64'd1);
    reset_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cdb_valid_o), 64'd0);
    chk("async_rst_data", 64'(cdb_data_o), 64'd0);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (5) step(5'b00000, 1'b0, 1'b0, 5'b00000);
    // Pointer back at 0 after reset: 0 beats 1.
    step(5'b00011, 1'b0, 1'b0, 5'b00001);
    step(5'b00000, 1'b0, 1'b0, 5'b00000);
    repeat (3) @(posedge clk_i);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus among the ALU reservation stations (res1..res4) and the branch reservation station (resbr).
- Each requester presents a completed result (ROB tag + data) with a valid/ready handshake.
- The arbiter grants one requester per cycle using rotating (round-robin) priority and registers the winner onto the CDB for the ROB, regfile and reservation stations.
- Supports ROB flush and downstream stall.

Parameters:
- N_REQ, 5, number of requesters; index N_REQ-1 is the branch station.
- TAG_W, 3, ROB tag width (8-entry ROB).
- DATA_W, 32, result data width.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  requester i holds a finished result.
- req_tag  input  N_REQ*TAG_W  ROB tag per requester; slice i = [i*TAG_W +: TAG_W].
- req_data  input  N_REQ*DATA_W  result per requester; slice i = [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- flush  input  1  ROB branch-mispredict flush.
- cdb_stall  input  1  downstream cannot accept a broadcast this cycle.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  TAG_W  broadcast ROB tag.
- cdb_data  output  DATA_W  broadcast data.
- cdb_src  output  $clog2(N_REQ)  index of the requester that produced the broadcast.

Behaviour:
- Reset (async, reset_n low):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - Priority pointer ptr=0.
  - req_ready is combinational and therefore 0 while in reset.
- Grant (combinational):
  - Active when !flush && !cdb_stall.
  - Winner = first i with req_valid[i], scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready = onehot(winner), or all-zero if no request, flush, or stall.
  - req_ready never depends on req_data or req_tag.
- Output register:
  - On a transfer, the next edge loads cdb_valid=1, cdb_tag/cdb_data = winner's slice, cdb_src = winner.
  - Otherwise the next edge loads cdb_valid=0; tag, data and src hold their old values.
  - Latency: exactly 1 cycle from handshake to broadcast.
  - cdb_valid is never high two cycles for the same transfer.
- Pointer:
  - After a transfer, ptr <= (winner+1) mod N_REQ, with wrap N_REQ-1 -> 0.
  - No transfer: ptr holds.
- Fairness: a requester holding req_valid continuously is granted within N_REQ grant-eligible cycles.
- Requester contract: a requester must hold valid, tag and data stable until it is granted. The arbiter does not buffer ungranted requests.
- Flush:
  - Forces req_ready=0 that cycle.
  - Next edge clears cdb_valid to 0, including a broadcast that would otherwise fire.
  - ptr holds.
- cdb_stall:
  - Blocks grants; cdb_valid=0 next cycle; ptr holds.
  - Does not cancel a broadcast already registered in the current cycle.
- flush and cdb_stall together: treated as flush.
- All requesters idle: cdb_valid=0, ptr holds.

Optional Feature:
- Macro: CDB_ARB_BR_PRIO_EN.
- Defined:
  - If req_valid[N_REQ-1] is high and the cycle is grant-eligible, the branch station always wins, so mispredicts resolve earliest.
  - Such grants do not advance ptr.
  - All other grants are round-robin as above.
  - The fairness bound applies only to cycles without a branch request.
- Undefined: the branch station is an ordinary round-robin requester.

Test Plan:
- Reset then idle: assert reset_n=0 mid-broadcast -> cdb_valid=0 immediately (async); after release, req_valid=0 for 5 cycles -> cdb_valid stays 0, ptr=0.
- Single request: req_valid=5'b00100, tag 3'd5, data 32'hDEADBEEF -> req_ready=5'b00100 that cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=2; ptr=3.
- All five requesting continuously from ptr=0 -> grant order 0,1,2,3,4,0; cdb_src sequence identical; each broadcast exactly one cycle.
- Wrap: ptr=4 with req_valid=5'b10001 -> grant 4, then 0; ptr goes 4->0->1.
- Flush/stall: req_valid=5'b00011 with flush=1 -> req_ready=0 and cdb_valid=0 next cycle, ptr unchanged. Repeat with cdb_stall=1 -> same result. Deassert both -> requester 0 is granted.
- With CDB_ARB_BR_PRIO_EN, req_valid=5'b10110 for 2 cycles from ptr=1: cycle 0 grants 4 (ptr stays 1); cycle 1, with req_valid[4] dropped after its grant, grants 1. Without the macro the same stimulus grants 1 then 2.
